sign_fetch_requester: RTL and testbench

- Initiator side of the sweep-match memory read interface.
- Accepts read addresses from upstream (sign-index lookup logic) into a small request FIFO, then presents each address on ADD.
- Waits for the memory's active-low CLR strobe and captures DATA into a valid/ready response register.
- Flags a timeout if no strobe arrives within one full sweep plus margin; one outstanding memory access at a time.

---
 rtl/sign_fetch_requester.sv | 178 +++++++++++++++++
 tb/tb_sign_fetch_requester.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sign_fetch_requester.sv
// Initiator side of the sweep-match memory read interface.
// Queues upstream read addresses, issues them one at a time on ADD, waits for the
// memory's active-low CLR strobe and returns the captured DATA (or ERR_DATA on timeout)
// through a valid/ready response register.
module sign_fetch_requester #(
  parameter int unsigned AW         = 6,
  parameter int unsigned DW         = 6,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 70,
  parameter int unsigned ERR_DATA   = 63
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          REQ_VALID,
  output logic          REQ_READY,
  input  logic [AW-1:0] REQ_ADDR,
  output logic [AW-1:0] ADD,
  input  logic          CLR,
  input  logic [DW-1:0] DATA,
  output logic          RSP_VALID,
  input  logic          RSP_READY,
  output logic [DW-1:0] RSP_DATA,
  output logic          RSP_ERR,
  output logic          BUSY,
  output logic [7:0]    ERR_CNT
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e        state;
  state_e        state_nxt;

  logic [AW-1:0] fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  logic [TW-1:0] tmo_cnt;
  logic          tmo_clr;
  logic          tmo_inc;
  logic          take_hit;
  logic          take_err;
  logic          rsp_done;

  // FIFO status; a full FIFO refuses a push even when a pop happens in the same cycle
  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign REQ_READY = !full;
  assign push      = REQ_VALID && REQ_READY;
  assign BUSY      = (state != S_IDLE) || !empty;

  // Request FIFO storage
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem[wr_ptr] <= REQ_ADDR;
    end
  end

  // Request FIFO pointers and occupancy
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state and datapath controls; CLR is only honoured in WAIT
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    tmo_clr   = 1'b0;
    tmo_inc   = 1'b0;
    take_hit  = 1'b0;
    take_err  = 1'b0;
    rsp_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = S_BLANK;
        end
      end
      S_BLANK: begin
        // registered CLR still reflects the previous ADD this cycle
        tmo_clr   = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        tmo_inc = 1'b1;
        if (!CLR) begin
          take_hit  = 1'b1;
          state_nxt = S_RESP;
        end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
          take_err  = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (RSP_VALID && RSP_READY) begin
          rsp_done  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address register, timeout counter, response register and error counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      ADD       <= '0;
      tmo_cnt   <= '0;
      RSP_VALID <= 1'b0;
      RSP_DATA  <= '0;
      RSP_ERR   <= 1'b0;
      ERR_CNT   <= '0;
    end else begin
      if (pop) begin
        ADD <= fifo_mem[rd_ptr];
      end
      if (tmo_clr) begin
        tmo_cnt <= '0;
      end else if (tmo_inc) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
      if (take_hit) begin
        RSP_DATA  <= DATA;
        RSP_ERR   <= 1'b0;
        RSP_VALID <= 1'b1;
      end else if (take_err) begin
        RSP_DATA  <= DW'(ERR_DATA);
        RSP_ERR   <= 1'b1;
        RSP_VALID <= 1'b1;
        if (ERR_CNT != 8'hFF) begin
          ERR_CNT <= ERR_CNT + 8'd1;
        end
      end else if (rsp_done) begin
        RSP_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sign_fetch_requester.sv
// Directed bench for sign_fetch_requester with a sweeping memory model,
// a direct CLR/DATA override, and a response scoreboard.
module tb_sign_fetch_requester;

  localparam int unsigned TIMEOUT = 70;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       REQ_VALID = 1'b0;
  logic       REQ_READY;
  logic [5:0] REQ_ADDR = 6'd0;
  logic [5:0] ADD;
  logic       CLR;
  logic [5:0] DATA;
  logic       RSP_VALID;
  logic       RSP_READY = 1'b1;
  logic [5:0] RSP_DATA;
  logic       RSP_ERR;
  logic       BUSY;
  logic [7:0] ERR_CNT;

  typedef struct packed {
    logic [5:0] addr;
    logic [5:0] data;
    logic       err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  // memory model: 6-bit sweep, registered strobe when the sweep hits ADD
  logic [5:0] sweep  = 6'd0;
  logic       clr_m  = 1'b1;
  logic [5:0] data_m = 6'd63;
  logic       mem_en = 1'b1;
  logic       ovr    = 1'b0;
  logic       clr_o  = 1'b1;
  logic [5:0] data_o = 6'd63;

  logic rsp_valid_q = 1'b0;
  logic clr_q       = 1'b1;

  assign CLR  = ovr ? clr_o  : clr_m;
  assign DATA = ovr ? data_o : data_m;

  always #5 CLK = ~CLK;

  sign_fetch_requester #(
    .AW(6), .DW(6), .FIFO_DEPTH(4), .TIMEOUT(TIMEOUT), .ERR_DATA(63)
  ) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ADDR(REQ_ADDR),
    .ADD(ADD), .CLR(CLR), .DATA(DATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
    .BUSY(BUSY), .ERR_CNT(ERR_CNT)
  );

  always @(posedge CLK) begin
    sweep <= sweep + 6'd1;
    if (mem_en && sweep == ADD) begin
      clr_m  <= 1'b0;
      data_m <= sweep;
    end else begin
      clr_m  <= 1'b1;
      data_m <= 6'd63;
    end
  end

  // response monitor: address/latency on rising RSP_VALID, payload on handshake
  always @(negedge CLK) begin
    if (RSP_VALID === 1'b1 && rsp_valid_q !== 1'b1 && sb.size() > 0) begin
      total++;
      assert (ADD === sb[0].addr) else begin
        bad++; $error("FAIL rsp_add got=%0d exp=%0d", ADD, sb[0].addr);
      end
      if (sb[0].err === 1'b0) begin
        total++;
        assert (clr_q === 1'b0) else begin
          bad++; $error("FAIL strobe_latency clr_prev got=%0b exp=0", clr_q);
        end
      end
    end
    if (RSP_VALID === 1'b1 && RSP_READY === 1'b1) begin
      total++;
      assert ((sb.size() > 0) === 1'b1) else begin
        bad++; $error("FAIL rsp_unexpected got=%0d exp=none", RSP_DATA);
      end
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        total++;
        assert (RSP_DATA === mon_e.data) else begin
          bad++; $error("FAIL rsp_data addr=%0d got=%0d exp=%0d", mon_e.addr, RSP_DATA, mon_e.data);
        end
        total++;
        assert (RSP_ERR === mon_e.err) else begin
          bad++; $error("FAIL rsp_err addr=%0d got=%0b exp=%0b", mon_e.addr, RSP_ERR, mon_e.err);
        end
      end
    end
    rsp_valid_q = RSP_VALID;
    clr_q       = CLR;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++; $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic push(input logic [5:0] a, input logic [5:0] d, input logic e, input bit track);
    int n = 0;
    REQ_VALID = 1'b1;
    REQ_ADDR  = a;
    while (REQ_READY !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    total++;
    assert (REQ_READY === 1'b1) else begin
      bad++; $error("FAIL push_ready addr=%0d got=%0b exp=1", a, REQ_READY);
    end
    if (REQ_READY === 1'b1) begin
      if (track) sb.push_back('{addr: a, data: d, err: e});
      tick();
    end
    REQ_VALID = 1'b0;
  endtask

  task automatic wait_add(input logic [5:0] a);
    int n = 0;
    while (ADD !== a && n < 400) begin
      tick();
      n++;
    end
    chk("wait_add", 32'(ADD), 32'(a));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((BUSY !== 1'b0 || RSP_VALID !== 1'b0) && n < 1000) begin
      tick();
      n++;
    end
    chk("wait_idle_busy", 32'(BUSY), 32'd0);
  endtask

  initial begin
    int n;
    // reset state
    RST = 1'b1;
    repeat (3) tick();
    RST = 1'b0;
    chk("rst_req_ready", 32'(REQ_READY), 32'd1);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    chk("rst_rsp_data", 32'(RSP_DATA), 32'd0);
    chk("rst_rsp_err", 32'(RSP_ERR), 32'd0);
    chk("rst_err_cnt", 32'(ERR_CNT), 32'd0);
    chk("rst_add", 32'(ADD), 32'd0);

    // single read hit through the sweeping memory
    push(6'd5, 6'd5, 1'b0, 1'b1);
    chk("busy_after_push", 32'(BUSY), 32'd1);
    wait_idle();

    // blocker plus four back-to-back requests fill the FIFO
    push(6'd1, 6'd1, 1'b0, 1'b1);
    push(6'd10, 6'd10, 1'b0, 1'b1);
    push(6'd20, 6'd20, 1'b0, 1'b1);
    push(6'd30, 6'd30, 1'b0, 1'b1);
    push(6'd40, 6'd40, 1'b0, 1'b1);
    chk("full_req_ready", 32'(REQ_READY), 32'd0);
    n = 0;
    while (REQ_READY !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    chk("ready_after_pop", 32'(REQ_READY), 32'd1);
    wait_idle();

    // stale strobe for the previous address during BLANK is ignored
    ovr = 1'b1; clr_o = 1'b1; data_o = 6'd63;
    push(6'd7, 6'd7, 1'b0, 1'b1);
    push(6'd8, 6'd8, 1'b0, 1'b1);
    wait_add(6'd7);
    tick();
    clr_o = 1'b0; data_o = 6'd7;
    tick();
    clr_o = 1'b1; data_o = 6'd63;
    wait_add(6'd8);
    clr_o = 1'b0; data_o = 6'd7;
    tick();
    clr_o = 1'b1; data_o = 6'd63;
    chk("stale_ignored", 32'(RSP_VALID), 32'd0);
    repeat (3) tick();
    chk("stale_still_waiting", 32'(RSP_VALID), 32'd0);
    clr_o = 1'b0; data_o = 6'd8;
    tick();
    clr_o = 1'b1; data_o = 6'd63;
    chk("hit_latency", 32'(RSP_VALID), 32'd1);
    wait_idle();

    // silent memory: timeout after exactly TIMEOUT WAIT cycles
    ovr = 1'b0; mem_en = 1'b0;
    repeat (2) tick();
    push(6'd12, 6'd63, 1'b1, 1'b1);
    wait_add(6'd12);
    n = 0;
    while (RSP_VALID !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("timeout_cycles", 32'(n), 32'(TIMEOUT + 1));
    chk("timeout_err_cnt", 32'(ERR_CNT), 32'd1);
    wait_idle();

    // strobe on the final WAIT cycle beats the timeout
    ovr = 1'b1; clr_o = 1'b1; data_o = 6'd63;
    push(6'd13, 6'd21, 1'b0, 1'b1);
    wait_add(6'd13);
    repeat (TIMEOUT) tick();
    chk("edge_no_rsp_yet", 32'(RSP_VALID), 32'd0);
    clr_o = 1'b0; data_o = 6'd21;
    tick();
    clr_o = 1'b1; data_o = 6'd63;
    chk("edge_rsp_valid", 32'(RSP_VALID), 32'd1);
    chk("edge_rsp_err", 32'(RSP_ERR), 32'd0);
    chk("edge_err_cnt", 32'(ERR_CNT), 32'd1);
    wait_idle();

    // downstream stall holds the response and blocks the next issue
    RSP_READY = 1'b0;
    push(6'd33, 6'd33, 1'b0, 1'b1);
    push(6'd34, 6'd34, 1'b0, 1'b1);
    wait_add(6'd33);
    tick();
    clr_o = 1'b0; data_o = 6'd33;
    tick();
    clr_o = 1'b1; data_o = 6'd63;
    for (int i = 0; i < 20; i++) begin
      chk("stall_hold", 32'({RSP_VALID, RSP_ERR, RSP_DATA, ADD}),
          32'({1'b1, 1'b0, 6'd33, 6'd33}));
      tick();
    end
    RSP_READY = 1'b1;
    wait_add(6'd34);
    tick();
    clr_o = 1'b0; data_o = 6'd34;
    tick();
    clr_o = 1'b1; data_o = 6'd63;
    wait_idle();

    // reset during WAIT with two entries queued aborts everything
    push(6'd50, 6'd0, 1'b0, 1'b0);
    push(6'd51, 6'd0, 1'b0, 1'b0);
    push(6'd52, 6'd0, 1'b0, 1'b0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("midrst_req_ready", 32'(REQ_READY), 32'd1);
    chk("midrst_rsp_valid", 32'(RSP_VALID), 32'd0);
    chk("midrst_busy", 32'(BUSY), 32'd0);
    chk("midrst_err_cnt", 32'(ERR_CNT), 32'd0);
    chk("midrst_add", 32'(ADD), 32'd0);
    repeat (3) tick();
    chk("midrst_stays_idle", 32'({BUSY, RSP_VALID}), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // 256 timeouts saturate the error counter
    for (int i = 0; i < 256; i++) begin
      push(6'(i), 6'd63, 1'b1, 1'b1);
    end
    wait_idle();
    chk("err_cnt_sat", 32'(ERR_CNT), 32'd255);
    chk("sb_final_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
